hpt_image_drawer: RTL and testbench
===================================

Name: hpt_image_drawer

Overview:
- VGA-side consumer of the HPT axis one-hot image code (10 image options).
- Detects a change in the selected image and converts the one-hot code to a binary ROM bank index.
- Sweeps an IMG_W x IMG_H pixel raster through a 1-cycle-latency image ROM and emits plot strobes with x/y/colour to the VGA adapter.
- Sits between the top-level image output and the VGA adapter plus image ROMs.

Parameters:
- IMG_W, 160, image width in pixels (x range 0..IMG_W-1)
- IMG_H, 120, image height in pixels (y range 0..IMG_H-1)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- ADDR_W, 15, ROM address width (must hold IMG_W*IMG_H-1)
- COL_W, 3, colour width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- image  in  10  one-hot image select from the axis core
- rom_data  in  COL_W  ROM pixel colour, valid one cycle after rom_addr
- rom_sel  out  4  binary bank index 0..9 of the image being drawn
- rom_addr  out  ADDR_W  linear pixel address = y*IMG_W + x
- x  out  X_W  plot x coordinate
- y  out  Y_W  plot y coordinate
- colour  out  COL_W  plot colour
- plot  out  1  pixel write strobe to the VGA adapter
- busy  out  1  high while drawing
- done  out  1  one-cycle pulse after the last pixel is plotted
- err  out  1  high while the image is not exactly one-hot

Behaviour:
- Reset (async, high) values:
  - all outputs 0
  - state IDLE
  - internal last_drawn = 10'b0, so the first valid code after reset always triggers a draw
- err is registered each cycle: 1 if image == 0 or more than one bit is set, else 0. An invalid code never starts a draw.
- States: IDLE, DRAW, FLUSH, DONE.
- IDLE:
  - If image is valid and image != last_drawn at edge T: latch image into last_drawn, set rom_sel = index of the set bit (bit k -> k), go to DRAW.
  - In DRAW at T+1, busy = 1, rom_addr = 0, internal counters xa = 0, ya = 0.
- DRAW, each cycle:
  - rom_addr increments by 1.
  - xa increments; at IMG_W-1 it wraps to 0 and ya increments.
  - The coordinates issued in cycle C are delayed one stage and appear on x/y in cycle C+1, together with colour = rom_data and plot = 1.
  - When the address issued is IMG_W*IMG_H-1, go to FLUSH.
- FLUSH: plots the final pixel (x = IMG_W-1, y = IMG_H-1), then goes to DONE.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Timing: first plot at T+2; last plot at T+1+IMG_W*IMG_H; done at the following cycle.
- plot is 0 in every cycle other than the IMG_W*IMG_H plot cycles. x/y/colour hold their last values when plot = 0.
- rom_sel is constant for the whole draw.
- A change of image during DRAW/FLUSH is ignored mid-frame. In IDLE after DONE it is compared against last_drawn and starts a new draw at once if different and valid.
- Reset mid-draw aborts immediately: plot drops the same cycle (async), and last_drawn clears, so the current code is redrawn after reset release.
- An image that stays unchanged and valid is never redrawn.

Test Plan (IMG_W=4, IMG_H=3 unless stated):
- Reset then image=10'b0000000100 -> rom_sel=2, busy rises at T+1, 12 plot pulses at T+2..T+13 with (x,y) in order (0,0),(1,0)..(3,2), rom_addr 0..11, done pulse at T+14.
- ROM model returns colour = addr[2:0] -> the colour at each plot equals the address issued the previous cycle (e.g. pixel (1,1) has colour 5).
- image=0, then image=10'b0000010010 -> err=1 each cycle, no plot, busy stays 0; then image=10'b1000000000 -> err=0, draw with rom_sel=9.
- Change image from bit 2 to bit 5 at the 4th plot -> first frame completes with rom_sel=2 (12 plots); second frame starts the cycle after done with rom_sel=5; holding bit 5 after that produces no third frame.
- Assert reset at the 6th plot -> plot/busy/rom_addr go to 0 immediately; after release with image unchanged, a full 12-pixel redraw occurs.
- Default parameters, single valid code -> exactly 19200 plots, last at (159,119) with rom_addr=19199, done one cycle later.

Source files
------------

// File: rtl/hpt_image_drawer.sv
// rtl/hpt_image_drawer.sv - one-hot image select to ROM-swept VGA pixel plotter
module hpt_image_drawer #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15,
  parameter int COL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        image,
  input  logic [COL_W-1:0]  rom_data,
  output logic [3:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [COL_W-1:0]  colour,
  output logic              plot,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);

  logic [1:0]        state_q, state_d;
  logic [9:0]        last_drawn_q, last_drawn_d;
  logic [3:0]        rom_sel_q, rom_sel_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [X_W-1:0]    xa_q, xa_d, x_q, x_d;
  logic [Y_W-1:0]    ya_q, ya_d, y_q, y_d;
  logic [COL_W-1:0]  colour_q, colour_d;
  logic              plot_q, plot_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              image_valid;
  logic [3:0]        image_idx;

  // Exactly-one-bit test and one-hot to bank index encoder
  always_comb begin
    image_valid = (image != 10'd0) && ((image & (image - 10'd1)) == 10'd0);
    image_idx   = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (image[k]) image_idx = 4'(k);
    end
  end

  // Frame sequencer: address/coordinate sweep with the plot stage one cycle behind the ROM
  always_comb begin
    state_d      = state_q;
    last_drawn_d = last_drawn_q;
    rom_sel_d    = rom_sel_q;
    rom_addr_d   = rom_addr_q;
    xa_d         = xa_q;
    ya_d         = ya_q;
    x_d          = x_q;
    y_d          = y_q;
    busy_d       = busy_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = ~image_valid;
    // The ROM word on the bus during a plot cycle is the colour being plotted; keep it for the hold value
    colour_d     = plot_q ? rom_data : colour_q;
    case (state_q)
      S_IDLE: begin
        if (image_valid && (image != last_drawn_q)) begin
          last_drawn_d = image;
          rom_sel_d    = image_idx;
          rom_addr_d   = '0;
          xa_d         = '0;
          ya_d         = '0;
          busy_d       = 1'b1;
          state_d      = S_DRAW;
        end
      end
      S_DRAW: begin
        plot_d = 1'b1;
        x_d    = xa_q;
        y_d    = ya_q;
        if (rom_addr_q == LAST_ADDR) begin
          state_d = S_FLUSH;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          if (xa_q == X_LAST) begin
            xa_d = '0;
            ya_d = ya_q + 1'b1;
          end else begin
            xa_d = xa_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears last_drawn so the current code is redrawn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_drawn_q <= '0;
      rom_sel_q    <= '0;
      rom_addr_q   <= '0;
      xa_q         <= '0;
      ya_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_drawn_q <= last_drawn_d;
      rom_sel_q    <= rom_sel_d;
      rom_addr_q   <= rom_addr_d;
      xa_q         <= xa_d;
      ya_q         <= ya_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rom_sel  = rom_sel_q;
  assign rom_addr = rom_addr_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = plot_q ? rom_data : colour_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_hpt_image_drawer.sv
// tb/tb_hpt_image_drawer.sv - self-checking bench for hpt_image_drawer
module tb_hpt_image_drawer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  image = 10'd0;
  logic [2:0]  rom_data = 3'd0;
  logic [3:0]  rom_sel;
  logic [14:0] rom_addr;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done, err;

  logic        reset_b = 1'b1;
  logic [9:0]  image_b = 10'd0;
  logic [2:0]  rom_data_b = 3'd0;
  logic [3:0]  rom_sel_b;
  logic [14:0] rom_addr_b;
  logic [7:0]  x_b;
  logic [6:0]  y_b;
  logic [2:0]  colour_b;
  logic        plot_b, busy_b, done_b, err_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  hpt_image_drawer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .image(image), .rom_data(rom_data),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done), .err(err)
  );

  hpt_image_drawer dut_big (
    .clk(clk), .reset(reset_b), .image(image_b), .rom_data(rom_data_b),
    .rom_sel(rom_sel_b), .rom_addr(rom_addr_b), .x(x_b), .y(y_b), .colour(colour_b),
    .plot(plot_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROMs whose word is the low three address bits
  always @(posedge clk) begin
    rom_data   <= rom_addr[2:0];
    rom_data_b <= rom_addr_b[2:0];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame model: a draw decided in cycle d busies d+1..d+1+N, plots pixel k at d+2+k, done at d+2+N
  bit         m_have = 0, m_prev = 0, m_err = 0;
  int         m_d = 0, m_sel_new = 0, m_sel_prev = 0;
  logic [9:0] m_last = 10'd0;
  int         m_lx = 0, m_ly = 0, m_lc = 0;
  int         rel, k, e_addr, e_sel, e_x, e_y, e_c;
  bit         e_plot, e_busy, e_done;

  always @(negedge clk) begin
    if (reset) begin
      m_have = 0; m_prev = 0; m_err = 0; m_sel_prev = 0; m_last = 10'd0;
      m_lx = 0; m_ly = 0; m_lc = 0;
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_sel", int'(rom_sel), 0);
      chk("rst_addr", int'(rom_addr), 0);
      chk("rst_xyc", int'({x, y, colour}), 0);
    end else begin
      rel    = m_have ? cyc - m_d : -1;
      e_plot = m_have && rel >= 2 && rel <= N + 1;
      e_busy = m_have && rel >= 1 && rel <= N + 1;
      e_done = m_have && rel == N + 2;
      e_sel  = (m_have && rel >= 1) ? m_sel_new : m_sel_prev;
      if (m_have && rel >= 1) e_addr = (rel - 1 < N - 1) ? rel - 1 : N - 1;
      else                    e_addr = m_prev ? N - 1 : 0;
      if (e_plot) begin
        k = rel - 2; e_x = k % W; e_y = k / W; e_c = k % 8;
      end else begin
        e_x = m_lx; e_y = m_ly; e_c = m_lc;
      end
      chk("plot", int'(plot), int'(e_plot));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(m_err));
      chk("rom_sel", int'(rom_sel), e_sel);
      chk("rom_addr", int'(rom_addr), e_addr);
      chk("x", int'(x), e_x);
      chk("y", int'(y), e_y);
      chk("colour", int'(colour), e_c);
      if (e_plot) begin
        m_lx = e_x; m_ly = e_y; m_lc = e_c;
      end
      if ((!m_have || cyc >= m_d + N + 3) && $countones(image) == 1 && image != m_last) begin
        if (m_have) begin
          m_prev = 1; m_sel_prev = m_sel_new;
        end
        m_have = 1; m_d = cyc; m_sel_new = $clog2(image); m_last = image;
      end
      m_err = ($countones(image) != 1);
    end
  end

  task automatic after_edge(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int r, np, first_off, done_off, col11, busy1, sel1, ndone, sel_a, sel_b;
  int last_x, last_y, last_addr, last_cyc, done_cyc;

  initial begin
    // Reset with bit 2 already selected
    image = 10'b0000000100;
    after_edge(3);
    @(negedge clk);
    chk("lit_rst_plot", int'(plot), 0);
    chk("lit_rst_busy", int'(busy), 0);
    chk("lit_rst_sel", int'(rom_sel), 0);
    after_edge(1);
    reset = 1'b0;
    r = cyc;
    np = 0; first_off = -1; done_off = -1; col11 = -1; busy1 = -1; sel1 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cyc - r == 1) begin busy1 = int'(busy); sel1 = int'(rom_sel); end
      if (plot) begin
        np++;
        if (first_off < 0) first_off = cyc - r;
        if (x == 8'd1 && y == 7'd1) col11 = int'(colour);
      end
      if (done && done_off < 0) done_off = cyc - r;
    end
    chk("lit_busy_t1", busy1, 1);
    chk("lit_sel_t1", sel1, 2);
    chk("lit_nplot", np, 12);
    chk("lit_first_plot", first_off, 2);
    chk("lit_done_off", done_off, 14);
    chk("lit_col_1_1", col11, 5);

    // Invalid codes: no draw, err held high
    after_edge(1);
    image = 10'd0;
    after_edge(5);
    image = 10'b0000010010;
    after_edge(5);
    @(negedge clk);
    chk("lit_err_multi", int'(err), 1);
    chk("lit_busy_invalid", int'(busy), 0);
    after_edge(1);
    image = 10'b1000000000;
    after_edge(3);
    @(negedge clk);
    chk("lit_sel9", int'(rom_sel), 9);
    after_edge(20);

    // Change of image mid-frame is deferred to the next frame
    image = 10'b0000000100;
    np = 0;
    for (int i = 0; i < 40 && np < 4; i++) begin
      @(negedge clk);
      if (plot) np++;
    end
    chk("lit_reach4", np, 4);
    after_edge(1);
    image = 10'b0000100000;
    ndone = 0; sel_a = -1; sel_b = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) sel_a = int'(rom_sel);
        if (ndone == 2) sel_b = int'(rom_sel);
      end
    end
    chk("lit_frames", ndone, 2);
    chk("lit_frame1_sel", sel_a, 2);
    chk("lit_frame2_sel", sel_b, 5);

    // Reset in the middle of a frame, then a full redraw of the same code
    after_edge(1);
    image = 10'b0000000100;
    np = 0;
    for (int i = 0; i < 40 && np < 6; i++) begin
      @(negedge clk);
      if (plot) np++;
    end
    chk("lit_reach6", np, 6);
    #1 reset = 1'b1;
    #1;
    chk("lit_abort_plot", int'(plot), 0);
    chk("lit_abort_busy", int'(busy), 0);
    chk("lit_abort_addr", int'(rom_addr), 0);
    after_edge(2);
    reset = 1'b0;
    np = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (plot) np++;
    end
    chk("lit_redraw", np, 12);

    // Full-size raster with default parameters
    image_b = 10'b0000001000;
    after_edge(1);
    reset_b = 1'b0;
    np = 0; last_x = -1; last_y = -1; last_addr = -1; last_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 19400 && done_cyc < 0; i++) begin
      @(negedge clk);
      if (plot_b) begin
        np++; last_x = int'(x_b); last_y = int'(y_b); last_addr = int'(rom_addr_b); last_cyc = cyc;
      end
      if (done_b) done_cyc = cyc;
    end
    chk("big_nplot", np, 19200);
    chk("big_last_x", last_x, 159);
    chk("big_last_y", last_y, 119);
    chk("big_last_addr", last_addr, 19199);
    chk("big_done_gap", done_cyc - last_cyc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
